keypad_lock_ctrl: RTL
=====================

// Module: keypad_lock_ctrl
// PURPOSE
//  Sequencing controller downstream of the 4x4 keypad scanner. It consumes the scanner's raw keycode and debounces it into
//  one-shot key events. It assembles digit entry, checks it against a code and drives unlock, error and lockout status.
//  It sits between the keypad scanner and the board LEDs/actuator logic in top_level.
// PARAMETERS
//  CODE_LEN     4          digits in the secret code (1..4)
//  CODE         16'h1234   secret code, one BCD nibble per digit, last digit in [3:0]
//  DEBOUNCE_CYC 500000     stable cycles to accept a press or a release (10 ms at 50 MHz)
//  UNLOCK_CYC   250000000  cycles the lock stays open (5 s)
//  FAIL_CYC     50000000   cycles the error indication is held (1 s)
//  MAX_TRIES    3          consecutive wrong codes before lockout (1..7)
//  LOCKOUT_CYC  500000000  cycles all keys are ignored after lockout (10 s)
// PORTS
//  CLOCK_50     in   1   system clock, 50 MHz
//  key0         in   1   asynchronous active-low reset
//  keycode      in   8   scanner output: [7]=key pressed, [3:0]=key (0-9 digits, A-D, E='*' clear, F='#' enter), [6:4] ignored
//  key_event    out  1   one-cycle pulse per accepted (debounced) press
//  key_value    out  4   value of last accepted key, valid from key_event onward
//  digit_count  out  3   digits currently entered (0..CODE_LEN)
//  entry        out  16  entered digits, newest in [3:0]
//  unlocked     out  1   high in OPEN
//  error        out  1   high in FAIL
//  locked_out   out  1   high in LOCKOUT
//  tries        out  3   consecutive wrong attempts
// BEHAVIOUR
//  Reset (key0=0, async assert, sync deassert): every output 0, FSM=ENTRY, timer=0, debouncer armed (treated as released).
//  Input path: keycode passes through a 2-flop synchronizer before any use.
//  Debounce:
//   - Counter tracks cycles the synchronized {[7],[3:0]} is unchanged.
//   - A press is accepted when armed and [7]=1 has been stable DEBOUNCE_CYC cycles.
//     key_event pulses exactly DEBOUNCE_CYC+2 cycles after keycode settles, then disarms.
//   - Re-arm requires [7]=0 stable DEBOUNCE_CYC cycles. A held key yields one event. A key change while held yields none.
//  FSM (one shared down-counter timer, width $clog2 of largest *_CYC):
//   - ENTRY digit 0-9: entry<={entry[11:0],d}, digit_count+1. If digit_count==CODE_LEN the digit is ignored (no shift).
//   - ENTRY E: entry=0, digit_count=0. A-D: ignored. F: -> CHECK.
//   - CHECK (exactly 1 cycle): match iff digit_count==CODE_LEN and entry[4*CODE_LEN-1:0]==CODE[4*CODE_LEN-1:0].
//     Entry and digit_count clear on exit.
//     - match -> OPEN, tries=0, timer=UNLOCK_CYC-1.
//     - mismatch and tries+1==MAX_TRIES -> LOCKOUT, timer=LOCKOUT_CYC-1, tries=MAX_TRIES.
//     - otherwise -> FAIL, tries+1, timer=FAIL_CYC-1.
//   - OPEN: timer reaches 0 -> ENTRY. E press relocks immediately -> ENTRY. Other keys ignored.
//   - FAIL: timer 0 -> ENTRY. All keys ignored.
//   - LOCKOUT: timer 0 -> ENTRY with tries=0. All keys ignored.
//  key_event/key_value fire in every state, including ignored keys. Key events during CHECK are dropped.
//  Simultaneous timer expiry and key event: expiry wins; the key is dropped.
//  Status outputs are registered and change on the cycle after the state transition edge.
//  Reset mid-operation (any state, mid-debounce) returns to reset values. No partial entry or tries survive.
// TESTING (bench params: DEBOUNCE_CYC=4 UNLOCK_CYC=20 FAIL_CYC=8 MAX_TRIES=3 LOCKOUT_CYC=30 CODE=16'h1234)
//  Press 8'h85 held 50 cycles with 2-cycle chatter at start -> exactly one key_event, key_value=5, digit_count=1.
//  Keys 1,2,3,4,F -> CHECK then unlocked=1 for 20 cycles, tries=0, then ENTRY with entry=0.
//  Keys 1,2,3,F (short) -> error=1 for 8 cycles, tries=1. Then 1,2,3,4,5,F -> fifth digit ignored, unlock.
//  Three wrong codes -> locked_out=1 for 30 cycles, key presses give key_event but no entry change, then tries=0.
//  Keys 1,2,E,1,2,3,4,F -> unlock. E during OPEN -> unlocked drops the following cycle.
//  Pull key0 low mid-entry and mid-OPEN -> all outputs 0 immediately. Next code entry works from zero.

Source files
------------

// File: rtl/keypad_lock_ctrl.sv
// Keypad lock sequencer: synchronizes and debounces scanner keycodes into one-shot key events,
// collects digit entry, compares it with CODE and sequences unlock / error / lockout status.
module keypad_lock_ctrl #(
    parameter int          CODE_LEN     = 4,
    parameter logic [15:0] CODE         = 16'h1234,
    parameter int          DEBOUNCE_CYC = 500000,
    parameter int          UNLOCK_CYC   = 250000000,
    parameter int          FAIL_CYC     = 50000000,
    parameter int          MAX_TRIES    = 3,
    parameter int          LOCKOUT_CYC  = 500000000
) (
    input  logic        CLOCK_50,
    input  logic        key0,
    input  logic [7:0]  keycode,
    output logic        key_event,
    output logic [3:0]  key_value,
    output logic [2:0]  digit_count,
    output logic [15:0] entry,
    output logic        unlocked,
    output logic        error,
    output logic        locked_out,
    output logic [2:0]  tries
);

    localparam int MAX_UF  = (UNLOCK_CYC > FAIL_CYC) ? UNLOCK_CYC : FAIL_CYC;
    localparam int MAX_CYC = (MAX_UF > LOCKOUT_CYC) ? MAX_UF : LOCKOUT_CYC;
    localparam int TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int DB_W    = $clog2(DEBOUNCE_CYC + 1);

    localparam logic [DB_W-1:0]    DB_MAX       = DB_W'(DEBOUNCE_CYC);
    localparam logic [TIMER_W-1:0] UNLOCK_LOAD  = TIMER_W'(UNLOCK_CYC - 1);
    localparam logic [TIMER_W-1:0] FAIL_LOAD    = TIMER_W'(FAIL_CYC - 1);
    localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYC - 1);
    localparam logic [15:0] ENTRY_MASK = (CODE_LEN >= 4) ? 16'hFFFF :
                                         16'((32'd1 << (4 * CODE_LEN)) - 32'd1);
    localparam logic [2:0] CODE_LEN_C  = 3'(CODE_LEN);
    localparam logic [2:0] MAX_TRIES_C = 3'(MAX_TRIES);
    localparam logic [3:0] KEY_CLEAR   = 4'hE;
    localparam logic [3:0] KEY_ENTER   = 4'hF;

    typedef enum logic [2:0] {
        S_ENTRY   = 3'd0,
        S_CHECK   = 3'd1,
        S_OPEN    = 3'd2,
        S_FAIL    = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    logic [1:0]         rst_sync_q;
    logic               rst_n;
    logic [4:0]         kc_meta_q;
    logic [4:0]         kc_sync_q;
    logic               keycode_unused_s;

    logic [4:0]         db_last_q, db_last_d;
    logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
    logic               db_stable_s;
    logic               armed_q, armed_d;
    logic               key_event_q, key_event_d;
    logic [3:0]         key_value_q, key_value_d;

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [15:0]        entry_q, entry_d;
    logic [2:0]         digit_count_q, digit_count_d;
    logic [2:0]         tries_q, tries_d;
    logic               unlocked_q, unlocked_d;
    logic               error_q, error_d;
    logic               locked_out_q, locked_out_d;
    logic               is_digit_s;
    logic               code_match_s;

    assign keycode_unused_s = ^keycode[6:4];

    // Reset synchronizer: assert immediately, release two clocks after key0 rises.
    always_ff @(posedge CLOCK_50 or negedge key0) begin
        if (!key0) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    // Two-flop synchronizer for the pressed flag and key code.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            kc_meta_q <= 5'b00000;
            kc_sync_q <= 5'b00000;
        end else begin
            kc_meta_q <= {keycode[7], keycode[3:0]};
            kc_sync_q <= kc_meta_q;
        end
    end

    // Debounce: count stable cycles, fire once per press, re-arm after a stable release.
    always_comb begin
        db_last_d   = kc_sync_q;
        db_cnt_d    = db_cnt_q;
        armed_d     = armed_q;
        key_event_d = 1'b0;
        key_value_d = key_value_q;
        if (kc_sync_q != db_last_q) begin
            db_cnt_d = DB_W'(1'b1);
        end else if (db_cnt_q == DB_MAX) begin
            db_cnt_d = db_cnt_q;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1'b1);
        end
        db_stable_s = (db_cnt_d == DB_MAX);
        if (db_stable_s && armed_q && kc_sync_q[4]) begin
            armed_d     = 1'b0;
            key_event_d = 1'b1;
            key_value_d = kc_sync_q[3:0];
        end else if (db_stable_s && !armed_q && !kc_sync_q[4]) begin
            armed_d = 1'b1;
        end else begin
            armed_d = armed_q;
        end
    end

    // Debounce state registers; the debouncer comes out of reset armed.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            db_last_q   <= 5'b00000;
            db_cnt_q    <= '0;
            armed_q     <= 1'b1;
            key_event_q <= 1'b0;
            key_value_q <= 4'h0;
        end else begin
            db_last_q   <= db_last_d;
            db_cnt_q    <= db_cnt_d;
            armed_q     <= armed_d;
            key_event_q <= key_event_d;
            key_value_q <= key_value_d;
        end
    end

    // Lock sequencer next state; timer expiry takes priority over a same-cycle key.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        entry_d       = entry_q;
        digit_count_d = digit_count_q;
        tries_d       = tries_q;
        is_digit_s    = (key_value_q <= 4'd9);
        code_match_s  = (digit_count_q == CODE_LEN_C) &&
                        ((entry_q & ENTRY_MASK) == (CODE & ENTRY_MASK));
        case (state_q)
            S_ENTRY: begin
                if (key_event_q) begin
                    if (is_digit_s) begin
                        if (digit_count_q != CODE_LEN_C) begin
                            entry_d       = {entry_q[11:0], key_value_q};
                            digit_count_d = digit_count_q + 3'd1;
                        end else begin
                            entry_d = entry_q;
                        end
                    end else if (key_value_q == KEY_CLEAR) begin
                        entry_d       = 16'h0000;
                        digit_count_d = 3'd0;
                    end else if (key_value_q == KEY_ENTER) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_ENTRY;
                    end
                end else begin
                    state_d = S_ENTRY;
                end
            end
            S_CHECK: begin
                entry_d       = 16'h0000;
                digit_count_d = 3'd0;
                if (code_match_s) begin
                    state_d = S_OPEN;
                    tries_d = 3'd0;
                    timer_d = UNLOCK_LOAD;
                end else if ((tries_q + 3'd1) == MAX_TRIES_C) begin
                    state_d = S_LOCKOUT;
                    tries_d = MAX_TRIES_C;
                    timer_d = LOCKOUT_LOAD;
                end else begin
                    state_d = S_FAIL;
                    tries_d = tries_q + 3'd1;
                    timer_d = FAIL_LOAD;
                end
            end
            S_OPEN: begin
                if (timer_q == '0) begin
                    state_d = S_ENTRY;
                end else if (key_event_q && (key_value_q == KEY_CLEAR)) begin
                    state_d = S_ENTRY;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - TIMER_W'(1'b1);
                end
            end
            S_FAIL: begin
                if (timer_q == '0) begin
                    state_d = S_ENTRY;
                end else begin
                    timer_d = timer_q - TIMER_W'(1'b1);
                end
            end
            S_LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d = S_ENTRY;
                    tries_d = 3'd0;
                end else begin
                    timer_d = timer_q - TIMER_W'(1'b1);
                end
            end
            default: begin
                state_d       = S_ENTRY;
                timer_d       = '0;
                entry_d       = 16'h0000;
                digit_count_d = 3'd0;
                tries_d       = 3'd0;
            end
        endcase
        unlocked_d   = (state_d == S_OPEN);
        error_d      = (state_d == S_FAIL);
        locked_out_d = (state_d == S_LOCKOUT);
    end

    // Sequencer and status registers.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_ENTRY;
            timer_q       <= '0;
            entry_q       <= 16'h0000;
            digit_count_q <= 3'd0;
            tries_q       <= 3'd0;
            unlocked_q    <= 1'b0;
            error_q       <= 1'b0;
            locked_out_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            entry_q       <= entry_d;
            digit_count_q <= digit_count_d;
            tries_q       <= tries_d;
            unlocked_q    <= unlocked_d;
            error_q       <= error_d;
            locked_out_q  <= locked_out_d;
        end
    end

    assign key_event   = key_event_q;
    assign key_value   = key_value_q;
    assign digit_count = digit_count_q;
    assign entry       = entry_q;
    assign unlocked    = unlocked_q;
    assign error       = error_q;
    assign locked_out  = locked_out_q;
    assign tries       = tries_q;

endmodule
